// File: rtl/seg_scan_if.sv
// seg_scan_if: bundle between the upstream segment source and the
// seven-segment scanner.
//   seg0..seg7  : per-digit segment bytes (seg0 -> digit 0)
//   freeze      : hold the current snapshot at the next capture point
//   an_n        : active-low digit enables
//   seg_out     : shared segment bus
//   frame_start : one-cycle pulse at each snapshot capture point
// master = segment source / display consumer side, slave = scanner.
interface seg_scan_if;
  logic [7:0] seg0;
  logic [7:0] seg1;
  logic [7:0] seg2;
  logic [7:0] seg3;
  logic [7:0] seg4;
  logic [7:0] seg5;
  logic [7:0] seg6;
  logic [7:0] seg7;
  logic       freeze;
  logic [7:0] an_n;
  logic [7:0] seg_out;
  logic       frame_start;

  modport master (
    output seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7, freeze,
    input  an_n, seg_out, frame_start
  );

  modport slave (
    input  seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7, freeze,
    output an_n, seg_out, frame_start
  );
endinterface

// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed driver for an 8-digit seven-segment display.
// Each digit owns a slot of CLK_DIV cycles; the first BLANK_CYCLES of every
// slot drive all digits off to suppress ghosting. The eight segment bytes
// are snapshotted together once per frame (start of digit 0's slot) so a
// frame never mixes old and new data.
// Ports:
//   clk  : system clock
//   rst  : asynchronous, active-low reset
//   bus  : seg_scan_if.slave (seg0..seg7, freeze in; an_n, seg_out,
//          frame_start out)
module seg_scan #(
  parameter int         CLK_DIV      = 1000,
  parameter int         BLANK_CYCLES = 16,
  parameter logic [7:0] BLANK_SEG    = 8'hFF
) (
  input logic       clk,
  input logic       rst,
  seg_scan_if.slave bus
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       dig_reg;
  logic [7:0]       shadow_reg  [8];
  logic [7:0]       shadow_next [8];
  logic [7:0]       seg_in      [8];
  logic             capture;

  assign seg_in[0] = bus.seg0;
  assign seg_in[1] = bus.seg1;
  assign seg_in[2] = bus.seg2;
  assign seg_in[3] = bus.seg3;
  assign seg_in[4] = bus.seg4;
  assign seg_in[5] = bus.seg5;
  assign seg_in[6] = bus.seg6;
  assign seg_in[7] = bus.seg7;

  // Capture point: first cycle of digit 0's slot.
  assign capture = (cnt_reg == '0) && (dig_reg == 3'd0);

  // Slot counter and digit index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
      dig_reg <= 3'd0;
    end else if (cnt_reg == CNT_LAST) begin
      cnt_reg <= '0;
      dig_reg <= dig_reg + 3'd1;   // natural 7 -> 0 wrap
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Per-digit snapshot. The output stage reads shadow_next so it sees the
  // value being captured on the same edge.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_shadow
      assign shadow_next[gi] = (capture && !bus.freeze) ? seg_in[gi]
                                                       : shadow_reg[gi];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          shadow_reg[gi] <= BLANK_SEG;
        end else begin
          shadow_reg[gi] <= shadow_next[gi];
        end
      end
    end
  endgenerate

  // Registered outputs. Only one enable bit can ever be low since the
  // pattern is a single shifted one, inverted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.an_n        <= 8'hFF;
      bus.seg_out     <= BLANK_SEG;
      bus.frame_start <= 1'b0;
    end else begin
      bus.frame_start <= capture;
      if (cnt_reg < BLANK_END) begin
        bus.an_n    <= 8'hFF;
        bus.seg_out <= BLANK_SEG;
      end else begin
        bus.an_n    <= ~(8'b1 << dig_reg);
        bus.seg_out <= shadow_next[dig_reg];
      end
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: directed checks for seg_scan with CLK_DIV=8, BLANK_CYCLES=2.
module tb_seg_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] seg_drv [8];
  logic       freeze_drv = 1'b0;
  int         edge_no = -1;
  int         n_checks = 0;
  int         n_fail = 0;

  seg_scan_if bus();

  assign bus.seg0   = seg_drv[0];
  assign bus.seg1   = seg_drv[1];
  assign bus.seg2   = seg_drv[2];
  assign bus.seg3   = seg_drv[3];
  assign bus.seg4   = seg_drv[4];
  assign bus.seg5   = seg_drv[5];
  assign bus.seg6   = seg_drv[6];
  assign bus.seg7   = seg_drv[7];
  assign bus.freeze = freeze_drv;

  seg_scan #(.CLK_DIV(8), .BLANK_CYCLES(2), .BLANK_SEG(8'hFF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         edge_n;
    logic [7:0] an;
    logic [7:0] sg;
    logic       fs;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s edge %0d: got %02h expected %02h", nm, edge_no, act, exp_v);
    end
  endtask

  // Advance to just after edge k, sampling on the following falling edge.
  task automatic goto(input int k);
    while (edge_no < k) begin
      @(posedge clk);
      edge_no++;
    end
    @(negedge clk);
  endtask

  task automatic release_rst();
    rst = 1'b1;
    edge_no = -1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    freeze_drv = 1'b0;
    for (int i = 0; i < 8; i++) seg_drv[i] = 8'h10 + 8'(i);
    repeat (3) @(negedge clk);
    chk("rst_an_n", bus.an_n, 8'hFF);
    chk("rst_seg_out", bus.seg_out, 8'hFF);
    chk("rst_frame_start", {7'd0, bus.frame_start}, 8'h00);
    release_rst();
  endtask

  task automatic check_table();
    for (int v = 0; v < 13; v++) begin
      goto(vecs[v].edge_n);
      chk("tbl_an_n", bus.an_n, vecs[v].an);
      chk("tbl_seg_out", bus.seg_out, vecs[v].sg);
      chk("tbl_frame_start", {7'd0, bus.frame_start}, {7'd0, vecs[v].fs});
    end
  endtask

  // Runs edges 0..last against a reference derived from the slot timing.
  task automatic run_model(input int scen, input int last);
    logic [7:0] sh_m [8];
    logic [7:0] an_e, sg_e, one;
    logic       fs_e;
    int         cnt_m, dig_m, pulses, prev_pos, ff_run, pos;
    one = 8'b1;
    pulses = 0;
    prev_pos = -1;
    ff_run = 0;
    for (int i = 0; i < 8; i++) sh_m[i] = 8'hFF;
    for (int e = 0; e <= last; e++) begin
      // stimulus for edge e, applied on the falling edge before it
      if (scen == 3 && e == 20) seg_drv[3] = 8'hA5;
      if (scen == 4 && e == 60) seg_drv[0] = 8'h3C;
      if (scen == 4 && e == 64) freeze_drv = 1'b1;
      if (scen == 4 && e == 128) freeze_drv = 1'b0;
      if (scen == 6) begin
        for (int i = 0; i < 8; i++) seg_drv[i] = 8'($urandom);
        freeze_drv = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      edge_no = e;
      cnt_m = e % 8;
      dig_m = (e / 8) % 8;
      fs_e = (cnt_m == 0 && dig_m == 0);
      if (fs_e && !freeze_drv) for (int i = 0; i < 8; i++) sh_m[i] = seg_drv[i];
      if (cnt_m < 2) begin
        an_e = 8'hFF;
        sg_e = 8'hFF;
      end else begin
        an_e = ~(one << dig_m);
        sg_e = sh_m[dig_m];
      end
      @(negedge clk);
      chk("mdl_an_n", bus.an_n, an_e);
      chk("mdl_seg_out", bus.seg_out, sg_e);
      chk("mdl_frame_start", {7'd0, bus.frame_start}, {7'd0, fs_e});
      if (bus.frame_start === 1'b1) pulses++;
      if (scen == 3 && e >= 26 && e <= 31) chk("s3_old_13", bus.seg_out, 8'h13);
      if (scen == 3 && e >= 90 && e <= 95) chk("s3_new_a5", bus.seg_out, 8'hA5);
      if (scen == 4 && e >= 66 && e <= 71) chk("s4_frozen_10", bus.seg_out, 8'h10);
      if (scen == 4 && e == 64) chk("s4_fs_frozen", {7'd0, bus.frame_start}, 8'h01);
      if (scen == 4 && e == 130) chk("s4_thaw_3c", bus.seg_out, 8'h3C);
      if (scen == 6) begin
        n_checks++;
        if ($countones(~bus.an_n) > 1) begin
          n_fail++;
          $display("FAIL overlap edge %0d: got an_n %02h required at most one low bit", e, bus.an_n);
        end
        if (bus.an_n == 8'hFF) begin
          ff_run++;
        end else begin
          pos = 0;
          for (int i = 0; i < 8; i++) if (bus.an_n[i] == 1'b0) pos = i;
          if (pos != prev_pos) begin
            n_checks++;
            if (prev_pos >= 0 && ff_run < 2) begin
              n_fail++;
              $display("FAIL blank_gap edge %0d: got %0d blank cycles required at least 2", e, ff_run);
            end
          end
          prev_pos = pos;
          ff_run = 0;
        end
      end
    end
    chk("pulse_count", 8'(pulses), 8'(last / 64 + 1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{0,  8'hFF, 8'hFF, 1'b1};
    vecs[1]  = '{1,  8'hFF, 8'hFF, 1'b0};
    vecs[2]  = '{2,  8'hFE, 8'h10, 1'b0};
    vecs[3]  = '{7,  8'hFE, 8'h10, 1'b0};
    vecs[4]  = '{8,  8'hFF, 8'hFF, 1'b0};
    vecs[5]  = '{9,  8'hFF, 8'hFF, 1'b0};
    vecs[6]  = '{10, 8'hFD, 8'h11, 1'b0};
    vecs[7]  = '{26, 8'hF7, 8'h13, 1'b0};
    vecs[8]  = '{58, 8'h7F, 8'h17, 1'b0};
    vecs[9]  = '{63, 8'h7F, 8'h17, 1'b0};
    vecs[10] = '{64, 8'hFF, 8'hFF, 1'b1};
    vecs[11] = '{65, 8'hFF, 8'hFF, 1'b0};
    vecs[12] = '{66, 8'hFE, 8'h10, 1'b0};

    // Scenario 1: reset and first frame
    do_reset();
    check_table();

    // Scenarios 2 and 3: periodicity and mid-frame input change
    do_reset();
    run_model(3, 140);

    // Scenario 4: freeze
    do_reset();
    run_model(4, 135);

    // Scenario 5: asynchronous reset mid-slot
    do_reset();
    goto(12);
    chk("s5_pre_an_n", bus.an_n, 8'hFD);
    chk("s5_pre_seg_out", bus.seg_out, 8'h11);
    #2 rst = 1'b0;
    #1;
    chk("s5_async_an_n", bus.an_n, 8'hFF);
    chk("s5_async_seg_out", bus.seg_out, 8'hFF);
    repeat (3) @(posedge clk);
    @(negedge clk);
    release_rst();
    check_table();

    // Scenario 6: random inputs, overlap and blanking gap
    do_reset();
    run_model(6, 999);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
